// File: rtl/ftsd_pkg.sv
// Shared constants and helpers for the multiplexed 14-segment display scan path.
// Holds the digit-count ceiling, the default code width and the active-low digit select encoder.
package ftsd_pkg;

    localparam int FTSD_MAX_DIGITS = 8;
    localparam int FTSD_IDX_W      = 3;
    localparam int FTSD_DATA_W     = 4;

    // Active-low one-cold select: only bit idx is low.
    function automatic logic [FTSD_MAX_DIGITS-1:0] digit_sel_n(input logic [FTSD_IDX_W-1:0] idx);
        logic [FTSD_MAX_DIGITS-1:0] sel;
        sel      = '1;
        sel[idx] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/ftsd_scan_prescaler.sv
// Dwell prescaler and digit index counter with anti-ghost blank generation.
// Combinational outputs straight from state registers; free-running, no backpressure.
module ftsd_scan_prescaler
    import ftsd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2,
    parameter int IDX_W     = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] scan_div,
    output logic [IDX_W-1:0] idx,
    output logic             cnt_zero,
    output logic             blank
);

    localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a scan_div lowered mid-dwell ends the slot at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt >= scan_div) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cnt_zero = (cnt == '0);
    // The terminal cycle of a dwell is never blanked, so every enabled digit lights.
    assign blank    = (cnt < BLANK_V) && (cnt < scan_div);

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// Scan controller for multiplexed common-anode 14-segment displays: digit select, code mux, frame strobe.
// Registered outputs, one cycle behind the scan state; free-running, no backpressure.
module ftsd_scan_ctrl
    import ftsd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = FTSD_DATA_W,
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIV_W-1:0]         scan_div,
    input  logic [DIGITS*DATA_W-1:0] digit_data,
    input  logic [DIGITS-1:0]        digit_en,
    output logic [DIGITS-1:0]        ftsd_ctl,
    output logic [DATA_W-1:0]        ftsd_in,
    output logic                     frame_start
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [IDX_W-1:0] idx;
    logic             cnt_zero;
    logic             blank;

    ftsd_scan_prescaler #(
        .DIGITS    (DIGITS),
        .DIV_W     (DIV_W),
        .BLANK_CYC (BLANK_CYC),
        .IDX_W     (IDX_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_div (scan_div),
        .idx      (idx),
        .cnt_zero (cnt_zero),
        .blank    (blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftsd_ctl    <= '1;
            ftsd_in     <= '0;
            frame_start <= 1'b0;
        end else begin
            ftsd_ctl    <= (blank || !digit_en[idx]) ? '1
                         : DIGITS'(digit_sel_n(FTSD_IDX_W'(idx)));
            ftsd_in     <= digit_data[idx*DATA_W +: DATA_W];
            frame_start <= cnt_zero && (idx == '0);
        end
    end

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// Directed vector table plus hand sequences for dwell shortening, async reset and a random one-cold sweep.
module tb_ftsd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] scan_div = 16'd3;
    logic [15:0] digit_data = 16'h1234;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  ftsd_ctl;
    logic [3:0]  ftsd_in;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ftsd_scan_ctrl #(
        .DIGITS    (4),
        .DATA_W    (4),
        .DIV_W     (16),
        .BLANK_CYC (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_div    (scan_div),
        .digit_data  (digit_data),
        .digit_en    (digit_en),
        .ftsd_ctl    (ftsd_ctl),
        .ftsd_in     (ftsd_in),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [15:0] div;
        logic [3:0]  en;
        logic [15:0] data;
        logic [3:0]  ctl;
        logic [3:0]  din;
        logic        fs;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;

    task automatic add(input logic [15:0] div, input logic [3:0] en,
                       input logic [3:0] ctl, input logic [3:0] din, input logic fs, input int rep);
        for (int r = 0; r < rep; r++) begin
            vt[nv] = '{div: div, en: en, data: 16'h1234, ctl: ctl, din: din, fs: fs};
            nv++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", 32'(ftsd_ctl), 32'hF);
        chk("reset_in", 32'(ftsd_in), 32'h0);
        chk("reset_fs", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_ctl[14];
    logic [3:0] exp_in[14];

    initial begin
        // Frame 1: all enabled, scan_div=3, one blank cycle per dwell.
        add(16'd3, 4'hF, 4'hF, 4'd4, 1'b1, 1);
        add(16'd3, 4'hF, 4'hE, 4'd4, 1'b0, 3);
        add(16'd3, 4'hF, 4'hF, 4'd3, 1'b0, 1);
        add(16'd3, 4'hF, 4'hD, 4'd3, 1'b0, 3);
        add(16'd3, 4'hF, 4'hF, 4'd2, 1'b0, 1);
        add(16'd3, 4'hF, 4'hB, 4'd2, 1'b0, 3);
        add(16'd3, 4'hF, 4'hF, 4'd1, 1'b0, 1);
        add(16'd3, 4'hF, 4'h7, 4'd1, 1'b0, 3);
        add(16'd3, 4'hF, 4'hF, 4'd4, 1'b1, 1);
        // Enable mask 1010: slots 0 and 2 stay dark, period still 16.
        add(16'd3, 4'hA, 4'hF, 4'd4, 1'b0, 3);
        add(16'd3, 4'hA, 4'hF, 4'd3, 1'b0, 1);
        add(16'd3, 4'hA, 4'hD, 4'd3, 1'b0, 3);
        add(16'd3, 4'hA, 4'hF, 4'd2, 1'b0, 4);
        add(16'd3, 4'hA, 4'hF, 4'd1, 1'b0, 1);
        add(16'd3, 4'hA, 4'h7, 4'd1, 1'b0, 3);
        add(16'd3, 4'hA, 4'hF, 4'd4, 1'b1, 1);
        // scan_div=0: a new digit every cycle, never blanked.
        add(16'd0, 4'hF, 4'hE, 4'd4, 1'b0, 1);
        for (int f = 0; f < 2; f++) begin
            add(16'd0, 4'hF, 4'hD, 4'd3, 1'b0, 1);
            add(16'd0, 4'hF, 4'hB, 4'd2, 1'b0, 1);
            add(16'd0, 4'hF, 4'h7, 4'd1, 1'b0, 1);
            add(16'd0, 4'hF, 4'hE, 4'd4, 1'b1, 1);
        end

        scan_div = vt[0].div;
        digit_en = vt[0].en;
        digit_data = vt[0].data;
        do_reset();
        for (int i = 0; i < nv; i++) begin
            scan_div = vt[i].div;
            digit_en = vt[i].en;
            digit_data = vt[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), 32'(ftsd_ctl), 32'(vt[i].ctl));
            chk($sformatf("vec%0d_in", i), 32'(ftsd_in), 32'(vt[i].din));
            chk($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vt[i].fs));
        end

        // Dwell shortened from 10 to 2 while cnt=6.
        exp_ctl = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hF, 4'hB, 4'hB, 4'hF};
        exp_in  = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1};
        scan_div = 16'd10;
        digit_en = 4'hF;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            if (k == 6) scan_div = 16'd2;
            @(negedge clk);
            if (k >= 1) begin
                chk($sformatf("shorten%0d_ctl", k), 32'(ftsd_ctl), 32'(exp_ctl[k]));
                chk($sformatf("shorten%0d_in", k), 32'(ftsd_in), 32'(exp_in[k]));
            end
        end

        // Async reset while digit 2 is lit.
        scan_div = 16'd3;
        do_reset();
        repeat (10) @(negedge clk);
        chk("pre_arst_ctl", 32'(ftsd_ctl), 32'hB);
        chk("pre_arst_in", 32'(ftsd_in), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", 32'(ftsd_ctl), 32'hF);
        chk("arst_in", 32'(ftsd_in), 32'h0);
        chk("arst_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("resume_fs", 32'(frame_start), 32'h1);
        chk("resume_ctl", 32'(ftsd_ctl), 32'hF);
        chk("resume_in", 32'(ftsd_in), 32'h4);
        @(negedge clk);
        chk("resume_lit_ctl", 32'(ftsd_ctl), 32'hE);
        chk("resume_lit_fs", 32'(frame_start), 32'h0);

        // Random sweep: never more than one digit selected.
        for (int c = 0; c < 10000; c++) begin
            digit_data = 16'($urandom);
            digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) scan_div = 16'($urandom_range(0, 6));
            @(negedge clk);
            chk("one_cold", 32'($countones(~ftsd_ctl) <= 1), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
